// File: rtl/decoder_pkg.sv
// Shared types and helpers for the scan_decoder family: FSM state encoding,
// a generic one-hot decoder and the output polarity helper.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // Widest select the helpers support; callers truncate the result to 2^N bits.
    localparam int MAX_N = 8;
    localparam int MAX_W = 1 << MAX_N;

    function automatic logic [MAX_W-1:0] onehot_decode(input logic [MAX_N-1:0] index,
                                                       input int n);
        logic [MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_W; i++) begin
            v[i] = (i < (1 << n)) && (index == MAX_N'(i));
        end
        return v;
    endfunction

    function automatic logic [MAX_W-1:0] apply_polarity(input logic [MAX_W-1:0] v,
                                                        input logic act_low);
        return act_low ? ~v : v;
    endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// Control/observation bundle of scan_decoder; the controller drives it as
// master, the decoder is the slave.
interface scan_decoder_if #(parameter int N = 2);

    localparam int W = 1 << N;

    logic         e;
    logic         mode;
    logic [N-1:0] x;
    logic         load;
    logic [W-1:0] y;
    logic [N-1:0] idx;
    logic         wrap;

    modport master (output e, mode, x, load, input  y, idx, wrap);
    modport slave  (input  e, mode, x, load, output y, idx, wrap);

endinterface

// File: rtl/scan_decoder_dwell.sv
// Dwell timer: counts cycles while running and pulses o_step on the last
// cycle of every DWELL-cycle period. A restart or a stop clears the count.
module dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    input  logic i_restart,
    output logic o_step
);

    localparam int            CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_run || i_restart || r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A restart suppresses the step so a reload always wins over a due step.
    assign o_step = i_run && !i_restart && (r_cnt == LAST);

endmodule

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with enable, direct and scan modes.
// Scan mode walks the active output through all positions, DWELL cycles each.
module scan_decoder
    import decoder_pkg::*;
#(
    parameter int N       = 2,
    parameter int DWELL   = 4,
    parameter int ACT_LOW = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    scan_decoder_if.slave  bus
);

    localparam int           W        = 1 << N;
    localparam logic [W-1:0] INACTIVE = (ACT_LOW != 0) ? {W{1'b1}} : {W{1'b0}};

    state_t       r_state;
    logic [N-1:0] r_idx;
    logic [W-1:0] r_y;
    logic         r_wrap;

    logic         w_run;
    logic         w_step;
    logic [N-1:0] w_next_idx;
    logic [W-1:0] w_dec_x;
    logic [W-1:0] w_dec_next;

    // The timer only runs while the FSM stays in SCAN; any entry edge clears it.
    assign w_run      = (r_state == SCAN) && bus.e && bus.mode;
    assign w_next_idx = r_idx + 1'b1;
    assign w_dec_x    = W'(apply_polarity(onehot_decode(MAX_N'(bus.x), N), ACT_LOW != 0));
    assign w_dec_next = W'(apply_polarity(onehot_decode(MAX_N'(w_next_idx), N), ACT_LOW != 0));

    dwell_timer #(.DWELL(DWELL)) u_dwell (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_run     (w_run),
        .i_restart (bus.load),
        .o_step    (w_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_y     <= INACTIVE;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (!bus.e) begin
                // idx deliberately holds its last value while disabled.
                r_state <= IDLE;
                r_y     <= INACTIVE;
            end else if (!bus.mode) begin
                r_state <= DIRECT;
                r_idx   <= bus.x;
                r_y     <= w_dec_x;
            end else begin
                case (r_state)
                    SCAN: begin
                        if (bus.load) begin
                            r_idx <= bus.x;
                            r_y   <= w_dec_x;
                        end else if (w_step) begin
                            r_idx  <= w_next_idx;
                            r_y    <= w_dec_next;
                            r_wrap <= &r_idx;
                        end
                    end
                    default: begin
                        // Scan entry from IDLE or DIRECT starts at x.
                        r_state <= SCAN;
                        r_idx   <= bus.x;
                        r_y     <= w_dec_x;
                    end
                endcase
            end
        end
    end

    assign bus.y    = r_y;
    assign bus.idx  = r_idx;
    assign bus.wrap = r_wrap;

endmodule
